// File: rtl/inst_prefetch_queue_pkg.sv
// Shared defaults, NOP encoding and FSM state encoding for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [15:0] NOP          = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } pq_state_e;

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// pq_fifo: small synchronous FIFO of {pc, instruction} entries with flush and occupancy count.
module pq_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = ADDR_W_DEF + DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers and count; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: one-outstanding imem fetcher feeding a PC-tagged FIFO.
// Optional INST_PREFETCH_BYPASS_EN forwards a response straight to the outputs when the queue is empty.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                       Clk,
  input  logic                       Rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_valid,
  input  logic [DATA_W-1:0]          imem_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  input  logic                       stall,
  output logic [DATA_W-1:0]          instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  pq_state_e         state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] req_pc, req_pc_nxt;
  logic              resp;
  logic              push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [ENT_W-1:0]  head;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_pc;

  // State, fetch PC and request strobe registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      imem_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      imem_req <= (state_nxt == REQ);
    end
  end

  // Next-state: request only when the response is guaranteed a slot
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    case (state)
      IDLE:    if (count < CNT_W'(DEPTH)) state_nxt = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_nxt    = WAIT;
          req_pc_nxt   = fetch_pc;
          fetch_pc_nxt = fetch_pc + ADDR_W'(1);
        end
      end
      WAIT:    if (imem_valid) state_nxt = IDLE;
      DISCARD: if (imem_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_nxt = redirect_addr;
      case (state)
        REQ:     state_nxt = imem_gnt ? DISCARD : IDLE;
        WAIT:    state_nxt = imem_valid ? IDLE : DISCARD;
        DISCARD: state_nxt = imem_valid ? IDLE : DISCARD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign imem_addr = fetch_pc;
  assign resp      = (state == WAIT) && imem_valid && !redirect;
  assign fifo_pop  = !fifo_empty && !stall;
  assign head_pc   = head[ENT_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];

`ifdef INST_PREFETCH_BYPASS_EN
  logic bypass_hit;

  // An unstalled response into an empty queue is consumed directly
  assign bypass_hit  = resp && fifo_empty;
  assign push        = resp && !(bypass_hit && !stall);
  assign instr_valid = !fifo_empty || bypass_hit;
  assign instr       = !fifo_empty ? head_data : (bypass_hit ? imem_data : DATA_W'(NOP));
  assign instr_pc    = !fifo_empty ? head_pc   : (bypass_hit ? req_pc    : '0);
`else
  assign push        = resp;
  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? DATA_W'(NOP) : head_data;
  assign instr_pc    = fifo_empty ? '0 : head_pc;
`endif

  pq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .flush (redirect),
    .push  (push),
    .pop   (fifo_pop),
    .wdata ({req_pc, imem_data}),
    .rdata (head),
    .count (count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed self-checking bench for inst_prefetch_queue (default build, no bypass).
module tb_inst_prefetch_queue;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_valid;
  logic [DW-1:0] imem_data;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          stall;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  // Memory responder model state
  bit            auto_mem;
  int            lat;
  bit            pend;
  int            pcnt;
  logic [AW-1:0] paddr;

  inst_prefetch_queue dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .stall         (stall),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .count         (count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'hC3A5 ^ a[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; the responder returns data lat cycles after a handshake
  task automatic step();
    logic          hs;
    logic [AW-1:0] ha;
    hs = imem_req && imem_gnt;
    ha = imem_addr;
    @(posedge Clk);
    #1;
    if (auto_mem) begin
      imem_valid = 1'b0;
      if (hs) begin
        pend  = 1'b1;
        pcnt  = lat;
        paddr = ha;
      end
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = mem_word(paddr);
          pend       = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    Rst      = 1'b1;
    redirect = 1'b0;
    stall    = 1'b0;
    step();
    step();
    pend       = 1'b0;
    imem_valid = 1'b0;
    Rst        = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_pc"}, instr_pc, 32'd0);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (!imem_req && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [AW-1:0] a, input int budget);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(imem_req && imem_addr == a), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    Rst           = 1'b1;
    imem_gnt      = 1'b0;
    imem_valid    = 1'b0;
    imem_data     = '0;
    redirect      = 1'b0;
    redirect_addr = '0;
    stall         = 1'b0;
    auto_mem      = 1'b1;
    lat           = 2;
    pend          = 1'b0;
    pcnt          = 0;
    paddr         = '0;

    // Free run, latency 2: PCs 0..3 in order
    do_reset();
    check_reset("t1_rst");
    imem_gnt = 1'b1;
    wait_req("t1_req", 10);
    chk("t1_addr0", imem_addr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      wait_valid("t1_valid", 20);
      chk("t1_pc", instr_pc, 32'(k));
      chk("t1_data", 32'(instr), 32'(mem_word(32'(k))));
      step();
    end

    // Stall held, latency 1: queue fills to 4, then drains one per cycle
    do_reset();
    lat   = 1;
    stall = 1'b1;
    repeat (30) step();
    chk("t2_full_count", 32'(count), 32'd4);
    chk("t2_full_req", 32'(imem_req), 32'd0);
    chk("t2_full_valid", 32'(instr_valid), 32'd1);
    chk("t2_full_pc", instr_pc, 32'd0);
    stall = 1'b0;
    step();
    chk("t2_c1_count", 32'(count), 32'd3);
    chk("t2_c1_pc", instr_pc, 32'd1);
    step();
    chk("t2_c2_count", 32'(count), 32'd2);
    chk("t2_c2_pc", instr_pc, 32'd2);
    chk("t2_c2_req", 32'(imem_req), 32'd1);
    chk("t2_c2_addr", imem_addr, 32'd4);
    step();
    chk("t2_c3_count", 32'(count), 32'd1);
    chk("t2_c3_pc", instr_pc, 32'd3);
    step();
    chk("t2_c4_count", 32'(count), 32'd1);
    chk("t2_c4_pc", instr_pc, 32'd4);

    // Redirect to 0x40 while waiting on the response for addr 5
    do_reset();
    lat = 3;
    wait_addr("t3_req2", 32'd2, 100);
    stall = 1'b1;
    wait_addr("t3_req5", 32'd5, 100);
    step();
    chk("t3_pre_count", 32'(count), 32'd3);
    chk("t3_pre_pc", instr_pc, 32'd2);
    redirect      = 1'b1;
    redirect_addr = 32'h40;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("t3_flush_count", 32'(count), 32'd0);
    chk("t3_flush_valid", 32'(instr_valid), 32'd0);
    wait_req("t3_req", 20);
    chk("t3_addr", imem_addr, 32'h40);
    wait_valid("t3_valid", 20);
    chk("t3_pc", instr_pc, 32'h40);
    chk("t3_data", 32'(instr), 32'(mem_word(32'h40)));

    // Redirect to 0x80 coinciding with imem_valid and a pop
    do_reset();
    lat   = 2;
    stall = 1'b1;
    wait_addr("t4_req2", 32'd2, 100);
    chk("t4_pre_count", 32'(count), 32'd2);
    step();
    step();
    redirect      = 1'b1;
    redirect_addr = 32'h80;
    stall         = 1'b0;
    step();
    redirect = 1'b0;
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_valid", 32'(instr_valid), 32'd0);
    chk("t4_pc", instr_pc, 32'd0);
    chk("t4_idle_req", 32'(imem_req), 32'd0);
    step();
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h80);
    wait_valid("t4_valid2", 20);
    chk("t4_first_pc", instr_pc, 32'h80);

    // Fetch PC wrap from FFFF_FFFF to 0
    do_reset();
    lat           = 1;
    redirect      = 1'b1;
    redirect_addr = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    wait_req("t5_req_a", 10);
    chk("t5_addr_max", imem_addr, 32'hFFFF_FFFF);
    wait_valid("t5_valid_a", 20);
    chk("t5_pc_max", instr_pc, 32'hFFFF_FFFF);
    chk("t5_data_max", 32'(instr), 32'(mem_word(32'hFFFF_FFFF)));
    step();
    wait_req("t5_req_b", 10);
    chk("t5_addr_wrap", imem_addr, 32'd0);
    wait_valid("t5_valid_b", 20);
    chk("t5_pc_wrap", instr_pc, 32'd0);
    chk("t5_data_wrap", 32'(instr), 32'(mem_word(32'd0)));

    // Reset during WAIT, then a stray response
    auto_mem = 1'b0;
    do_reset();
    imem_gnt = 1'b1;
    wait_req("t6_req", 10);
    chk("t6_addr", imem_addr, 32'd0);
    step();
    imem_gnt = 1'b0;
    Rst      = 1'b1;
    step();
    Rst = 1'b0;
    check_reset("t6_rst");
    imem_valid = 1'b1;
    imem_data  = 16'hDEAD;
    step();
    imem_valid = 1'b0;
    chk("t6_stray_valid", 32'(instr_valid), 32'd0);
    chk("t6_stray_count", 32'(count), 32'd0);
    chk("t6_req_after", 32'(imem_req), 32'd1);
    chk("t6_addr_after", imem_addr, 32'd0);
    repeat (3) step();
    chk("t6_late_valid", 32'(instr_valid), 32'd0);
    chk("t6_late_instr", 32'(instr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
